// File: rtl/id_ex_skid_pkg.sv
// Shared ID/EX definitions: bus widths, NOP encodings and skid FSM states.
package id_ex_skid_pkg;

  localparam int unsigned AluOpBus   = 8;
  localparam int unsigned AluSelBus  = 3;
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        RstEnable    = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/id_ex_skid_payload_reg.sv
// Flat payload register with async reset, synchronous clear-to-NOP and load enable.
module id_ex_payload_reg
  import id_ex_skid_pkg::*;
#(
  parameter int unsigned W         = 1,
  parameter logic [W-1:0] NOP_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Clear wins over load so a flush can never latch the same-cycle input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      data_q <= NOP_VAL;
    end else if (clr_i) begin
      data_q <= NOP_VAL;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with one-entry skid buffer (registered backpressure).
// Optional performance counters enabled by defining ID_EX_PERF_EN.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int unsigned AOP_W  = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [AOP_W-1:0]  id_aluop,
  input  logic [SEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [DATA_W-1:0] id_reg2,
  input  logic [ADDR_W-1:0] id_wd,
  input  logic              id_wreg,
  input  logic [DATA_W-1:0] id_link,
  input  logic              id_in_dslot,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [AOP_W-1:0]  ex_aluop,
  output logic [SEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [ADDR_W-1:0] ex_wd,
  output logic              ex_wreg,
  output logic [DATA_W-1:0] ex_link,
  output logic              ex_in_dslot
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int unsigned PW = AOP_W + SEL_W + 3 * DATA_W + ADDR_W + 2;
  localparam logic [PW-1:0] NOP_PL = {
    AOP_W'(EXE_NOP_OP), SEL_W'(EXE_RES_NOP), DATA_W'(ZeroWord), DATA_W'(ZeroWord),
    ADDR_W'(NOPRegAddr), WriteDisable, DATA_W'(ZeroWord), 1'b0
  };

  state_e state_q, state_d;

  logic [PW-1:0] id_pl, out_pl, skid_pl, out_d;
  logic accept, retire;
  logic out_ld, out_clr, out_from_skid, skid_ld, skid_clr;

  assign id_pl = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_link, id_in_dslot};

  assign id_ready = (state_q != ST_FULL);
  assign ex_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign accept   = id_valid && id_ready;
  assign retire   = ex_valid && ex_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // The output slot is cleared whenever it drains so bubbles always carry NOP.
  always_comb begin
    state_d       = state_q;
    out_ld        = 1'b0;
    out_clr       = 1'b0;
    out_from_skid = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      out_clr  = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            out_ld  = 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && retire) begin
            out_ld = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (retire) begin
            state_d = ST_EMPTY;
            out_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (retire) begin
            state_d       = ST_BUSY;
            out_ld        = 1'b1;
            out_from_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          out_clr  = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign out_d = out_from_skid ? skid_pl : id_pl;

  id_ex_payload_reg #(.W(PW), .NOP_VAL(NOP_PL)) u_out_slot (
    .clk   (clk),
    .rst   (rst),
    .clr_i (out_clr),
    .ld_i  (out_ld),
    .d_i   (out_d),
    .q_o   (out_pl)
  );

  id_ex_payload_reg #(.W(PW), .NOP_VAL(NOP_PL)) u_skid_slot (
    .clk   (clk),
    .rst   (rst),
    .clr_i (skid_clr),
    .ld_i  (skid_ld),
    .d_i   (id_pl),
    .q_o   (skid_pl)
  );

  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link, ex_in_dslot} = out_pl;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (ex_valid && !ex_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!ex_valid && (bubble_cnt_q != '1))            bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != '1))                  flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Self-checking bench for id_ex_skid: directed scenarios plus random traffic vs a queue model.
module tb_id_ex_skid;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link;
    logic        dslot;
  } pl_t;

  logic clk = 1'b0;
  logic rst, flush, id_valid, id_ready, ex_valid, ex_ready;
  logic [7:0]  id_aluop, ex_aluop;
  logic [2:0]  id_alusel, ex_alusel;
  logic [31:0] id_reg1, id_reg2, id_link, ex_reg1, ex_reg2, ex_link;
  logic [4:0]  id_wd, ex_wd;
  logic        id_wreg, ex_wreg, id_in_dslot, ex_in_dslot;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
  logic [15:0] perf_flush_cnt;
  logic [31:0] m_stall, m_bubble;
  logic [15:0] m_flush;
`endif

  int unsigned total = 0;
  int unsigned bad = 0;
  pl_t mq[$];

  always #5 clk = ~clk;

  id_ex_skid #(.AOP_W(8), .SEL_W(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_link(id_link), .id_in_dslot(id_in_dslot),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_link(ex_link), .ex_in_dslot(ex_in_dslot)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic pl_t dut_pl();
    return {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link, ex_in_dslot};
  endfunction

  // NOP payload is all zeros in every field.
  task automatic check_all();
    pl_t exp;
    exp = (mq.size() > 0) ? mq[0] : pl_t'(0);
    chk("ex_valid", 128'(ex_valid), 128'(mq.size() > 0));
    chk("id_ready", 128'(id_ready), 128'(mq.size() < 2));
    chk("ex_payload", 128'(dut_pl()), 128'(exp));
`ifdef ID_EX_PERF_EN
    chk("perf_stall", 128'(perf_stall_cnt), 128'(m_stall));
    chk("perf_bubble", 128'(perf_bubble_cnt), 128'(m_bubble));
    chk("perf_flush", 128'(perf_flush_cnt), 128'(m_flush));
`endif
  endtask

  function automatic pl_t mk(input logic [31:0] r1);
    pl_t p;
    p = '0;
    p.aluop = 8'h21;
    p.alusel = 3'b001;
    p.reg1 = r1;
    p.reg2 = ~r1;
    p.wd = 5'd3;
    p.wreg = 1'b1;
    return p;
  endfunction

  function automatic pl_t rnd_pl();
    pl_t p;
    p.aluop = 8'($urandom);
    p.alusel = 3'($urandom);
    p.reg1 = $urandom;
    p.reg2 = $urandom;
    p.wd = 5'($urandom);
    p.wreg = 1'($urandom);
    p.link = $urandom;
    p.dslot = 1'($urandom);
    return p;
  endfunction

  // Called at the falling edge: drive, advance the model across one rising edge, check.
  task automatic step(input logic v, input logic rdy, input logic fl, input pl_t p);
    int unsigned n;
    logic acc, ret;
    id_valid = v; ex_ready = rdy; flush = fl;
    {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_link, id_in_dslot} = p;
    n = mq.size();
    acc = v && (n < 2);
    ret = (n > 0) && rdy;
`ifdef ID_EX_PERF_EN
    if (n > 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (n == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
    if (fl && m_flush != 16'hFFFF) m_flush++;
`endif
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    check_all();
    @(negedge clk);
  endtask

  initial begin
    pl_t a, b, c, pt;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_link, id_in_dslot} = '0;
`ifdef ID_EX_PERF_EN
    m_stall = '0; m_bubble = '0; m_flush = '0;
`endif
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, 1'b0, mk(k));
      chk("stream_reg1", 128'(ex_reg1), 128'(k));
      chk("stream_ready", 128'(id_ready), 128'(1));
    end
    step(1'b0, 1'b1, 1'b0, '0);

    a = mk(32'hA); b = mk(32'hB); c = mk(32'hC);
    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, b);
    chk("bp_ready", 128'(id_ready), 128'(0));
    chk("bp_reg1", 128'(ex_reg1), 128'(32'hA));
    for (int unsigned k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, c);
    chk("bp_hold", 128'(ex_reg1), 128'(32'hA));
    step(1'b0, 1'b1, 1'b0, '0);
    chk("bp_second", 128'(ex_reg1), 128'(32'hB));
    step(1'b0, 1'b1, 1'b0, '0);
    chk("bp_empty", 128'(ex_valid), 128'(0));
    chk("bp_wreg", 128'(ex_wreg), 128'(0));

    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, b);
    step(1'b1, 1'b0, 1'b1, c);
    chk("flush_valid", 128'(ex_valid), 128'(0));
    chk("flush_ready", 128'(id_ready), 128'(1));
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("flush_drop", 128'(ex_valid), 128'(0));

    pt = '0;
    pt.link = 32'h0040_0008; pt.dslot = 1'b1; pt.wd = 5'd31; pt.wreg = 1'b1;
    step(1'b1, 1'b1, 1'b0, pt);
    chk("pt_link", 128'(ex_link), 128'(32'h0040_0008));
    chk("pt_dslot", 128'(ex_in_dslot), 128'(1));
    chk("pt_wd", 128'(ex_wd), 128'(31));
    chk("pt_wreg", 128'(ex_wreg), 128'(1));

    for (int unsigned k = 0; k < 400; k++)
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, rnd_pl());

    step(1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, b);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 128'(ex_valid), 128'(0));
    chk("rst_ready", 128'(id_ready), 128'(1));
    chk("rst_aluop", 128'(ex_aluop), 128'(0));
    chk("rst_wd", 128'(ex_wd), 128'(0));
    chk("rst_reg1", 128'(ex_reg1), 128'(0));
    mq.delete();
`ifdef ID_EX_PERF_EN
    m_stall = '0; m_bubble = '0; m_flush = '0;
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned k = 0; k < 100; k++)
      step(($urandom % 2) != 0, ($urandom % 2) != 0, ($urandom % 25) == 0, rnd_pl());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
